hwpe_eai_slave_if: RTL and testbench
====================================

// Module: hwpe_eai_slave_if
// PURPOSE
//  HWPE-side responder for the EAI coprocessor interface; counterpart to the rv_mcu initiator.
//  Accepts custom instructions (instr/rs1/rs2/itag) and forwards legal ones to the instruction decoder.
//  Returns exactly one in-order response per accepted instruction, with the matching itag.
//  Illegal opcodes are answered with err=1 and are never forwarded to the decoder.
// PARAMETERS
//  DEPTH   4   max outstanding instructions (itag FIFO entries), power of 2, >=2
//  ITAG_W  2   itag width
//  DATA_W  32  instr/rs1/rs2/wdat width
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, synchronous, active-high
//  eai_req_valid  in   1       request valid
//  eai_req_ready  out  1       request ready
//  eai_req_instr  in   DATA_W  instruction word
//  eai_req_rs1    in   DATA_W  rs1 operand
//  eai_req_rs2    in   DATA_W  rs2 operand
//  eai_req_itag   in   ITAG_W  instruction tag
//  eai_rsp_valid  out  1       response valid
//  eai_rsp_ready  in   1       response ready
//  eai_rsp_wdat   out  DATA_W  writeback data (0 when xd=0 or err)
//  eai_rsp_itag   out  ITAG_W  tag of the responded instruction
//  eai_rsp_err    out  1       1 = illegal instruction
//  cmd_valid      out  1       command to decoder valid
//  cmd_ready      in   1       decoder accepts command
//  cmd_instr      out  DATA_W  forwarded instruction word
//  cmd_rs1        out  DATA_W  forwarded rs1
//  cmd_rs2        out  DATA_W  forwarded rs2
//  done_valid     in   1       decoder completion, in command order
//  done_ready     out  1       completion accepted
//  done_wdat      in   DATA_W  completion result
// BEHAVIOUR
//  Reset: all outputs 0; itag FIFO, cmd register and response register are emptied.
//   rst mid-operation drops every in-flight instruction; no response is issued for it.
//  Legal = instr[6:0] in {7'h0B,7'h2B,7'h5B,7'h7B}; xd = instr[14].
//  Request accept: eai_req_valid & eai_req_ready.
//   eai_req_ready = !fifo_full & (!cmd_valid | cmd_ready).
//   No same-cycle full bypass: a pop while full does not raise ready in that cycle.
//  On accept: push {itag, xd, illegal} into the FIFO.
//   If legal, the cmd register loads instr/rs1/rs2; cmd_valid=1 from the next cycle (1-cycle latency).
//   It holds, with data stable, until cmd_valid & cmd_ready.
//  Response register (1 entry), loaded only when empty or draining this cycle (eai_rsp_ready):
//   head illegal -> load {wdat=0, err=1, itag=head.itag} without waiting for the decoder.
//   head legal   -> done_ready=1; on done_valid & done_ready load {wdat=xd?done_wdat:0, err=0}.
//   done_ready=0 whenever the FIFO is empty or the head entry is illegal.
//  eai_rsp_valid rises the cycle after the load and holds with stable data until eai_rsp_ready.
//   The FIFO head pops when the response register loads.
//   Back-to-back responses: one per cycle while eai_rsp_ready=1.
//  Simultaneous push & pop: occupancy count unchanged; pointers wrap modulo DEPTH.
//  Ordering: responses strictly follow request acceptance order, whatever the itag values are.
// TESTING
//  1 legal instr 0x0000407B, itag=1, decoder done_wdat=0x12345678 -> rsp itag=1, wdat=0x12345678, err=0.
//  2 instr 0x0000007B (xd=0), done_wdat=0xFFFF_FFFF -> rsp wdat=0, err=0.
//  3 instr 0x00000033, itag=2 -> no cmd_valid; rsp err=1, itag=2, wdat=0, 2 cycles after accept.
//  4 DEPTH+1 back-to-back requests, cmd_ready=0 -> only 1 accepted until cmd_ready; occupancy never exceeds DEPTH.
//  5 tags 0,1,2(illegal),3 with eai_rsp_ready toggling -> rsp order 0,1,2,3; data stable while stalled.
//  6 rst asserted with 3 outstanding -> next cycle all valids 0; after release, new itag=0 answered normally.

Source files
------------

// File: rtl/hwpe_eai_slave_if_if.sv
`default_nettype none
// ============================================================================
//  Module   : hwpe_eai_slave_if_if
//  Brief    : EAI request/response, decoder command and completion bundle.
//  Revision : 1.0
// ============================================================================
interface hwpe_eai_slave_if_if #(
    parameter int ITAG_W = 2,
    parameter int DATA_W = 32
);
    logic              eai_req_valid;
    logic              eai_req_ready;
    logic [DATA_W-1:0] eai_req_instr;
    logic [DATA_W-1:0] eai_req_rs1;
    logic [DATA_W-1:0] eai_req_rs2;
    logic [ITAG_W-1:0] eai_req_itag;
    logic              eai_rsp_valid;
    logic              eai_rsp_ready;
    logic [DATA_W-1:0] eai_rsp_wdat;
    logic [ITAG_W-1:0] eai_rsp_itag;
    logic              eai_rsp_err;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_instr;
    logic [DATA_W-1:0] cmd_rs1;
    logic [DATA_W-1:0] cmd_rs2;
    logic              done_valid;
    logic              done_ready;
    logic [DATA_W-1:0] done_wdat;

    modport slave (
        input  eai_req_valid, eai_req_instr, eai_req_rs1, eai_req_rs2, eai_req_itag,
        output eai_req_ready,
        output eai_rsp_valid, eai_rsp_wdat, eai_rsp_itag, eai_rsp_err,
        input  eai_rsp_ready,
        output cmd_valid, cmd_instr, cmd_rs1, cmd_rs2,
        input  cmd_ready,
        input  done_valid, done_wdat,
        output done_ready
    );

    modport master (
        output eai_req_valid, eai_req_instr, eai_req_rs1, eai_req_rs2, eai_req_itag,
        input  eai_req_ready,
        input  eai_rsp_valid, eai_rsp_wdat, eai_rsp_itag, eai_rsp_err,
        output eai_rsp_ready,
        input  cmd_valid, cmd_instr, cmd_rs1, cmd_rs2,
        output cmd_ready,
        output done_valid, done_wdat,
        input  done_ready
    );
endinterface
`default_nettype wire

// File: rtl/hwpe_eai_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : hwpe_eai_slave_if
//  Brief    : EAI responder; forwards legal instructions to the decoder and
//             returns one in-order response per accepted instruction.
//  Revision : 1.0
// ============================================================================
module hwpe_eai_slave_if #(
    parameter int DEPTH  = 4,
    parameter int ITAG_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    hwpe_eai_slave_if_if.slave  bus
);
    localparam int                c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]   c_cnt_full = (c_ptr_w + 1)'(DEPTH);

    // Outstanding-instruction FIFO: {itag, xd, illegal} per accepted request
    logic [ITAG_W-1:0]  r_fifo_tag [DEPTH];
    logic [DEPTH-1:0]   r_fifo_xd;
    logic [DEPTH-1:0]   r_fifo_ill;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic               r_cmd_valid;
    logic [DATA_W-1:0]  r_cmd_instr;
    logic [DATA_W-1:0]  r_cmd_rs1;
    logic [DATA_W-1:0]  r_cmd_rs2;

    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_wdat;
    logic [ITAG_W-1:0]  r_rsp_itag;
    logic               r_rsp_err;

    logic [6:0]         w_opcode;
    logic               w_legal;
    logic               w_xd;
    logic               w_full;
    logic               w_empty;
    logic               w_req_ready;
    logic               w_push;
    logic               w_head_ill;
    logic               w_head_xd;
    logic [ITAG_W-1:0]  w_head_tag;
    logic               w_rsp_free;
    logic               w_done_ready;
    logic               w_rsp_load;

    assign w_opcode = bus.eai_req_instr[6:0];
    assign w_xd     = bus.eai_req_instr[14];
    assign w_legal  = (w_opcode == 7'h0B) || (w_opcode == 7'h2B) ||
                      (w_opcode == 7'h5B) || (w_opcode == 7'h7B);

    assign w_full  = (r_count == c_cnt_full);
    assign w_empty = (r_count == '0);

    // Ready depends only on registered occupancy, so a pop never frees a slot combinationally
    assign w_req_ready = !rst && !w_full && (!r_cmd_valid || bus.cmd_ready);
    assign w_push      = bus.eai_req_valid && w_req_ready;

    assign w_head_tag = r_fifo_tag[r_rd_ptr];
    assign w_head_xd  = r_fifo_xd[r_rd_ptr];
    assign w_head_ill = r_fifo_ill[r_rd_ptr];

    assign w_rsp_free   = !r_rsp_valid || bus.eai_rsp_ready;
    assign w_done_ready = !rst && !w_empty && !w_head_ill && w_rsp_free;
    assign w_rsp_load   = !rst && !w_empty && w_rsp_free &&
                          (w_head_ill || bus.done_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rsp_load) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_rsp_load})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_tag[r_wr_ptr] <= bus.eai_req_itag;
            r_fifo_xd[r_wr_ptr]  <= w_xd;
            r_fifo_ill[r_wr_ptr] <= !w_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_valid <= 1'b0;
            r_cmd_instr <= '0;
            r_cmd_rs1   <= '0;
            r_cmd_rs2   <= '0;
        end else if (w_push && w_legal) begin
            r_cmd_valid <= 1'b1;
            r_cmd_instr <= bus.eai_req_instr;
            r_cmd_rs1   <= bus.eai_req_rs1;
            r_cmd_rs2   <= bus.eai_req_rs2;
        end else if (r_cmd_valid && bus.cmd_ready) begin
            r_cmd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_wdat  <= '0;
            r_rsp_itag  <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_rsp_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_itag  <= w_head_tag;
            r_rsp_err   <= w_head_ill;
            r_rsp_wdat  <= (w_head_ill || !w_head_xd) ? '0 : bus.done_wdat;
        end else if (bus.eai_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.eai_req_ready = w_req_ready;
    assign bus.eai_rsp_valid = r_rsp_valid;
    assign bus.eai_rsp_wdat  = r_rsp_wdat;
    assign bus.eai_rsp_itag  = r_rsp_itag;
    assign bus.eai_rsp_err   = r_rsp_err;
    assign bus.cmd_valid     = r_cmd_valid;
    assign bus.cmd_instr     = r_cmd_instr;
    assign bus.cmd_rs1       = r_cmd_rs1;
    assign bus.cmd_rs2       = r_cmd_rs2;
    assign bus.done_ready    = w_done_ready;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_eai_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hwpe_eai_slave_if
//  Brief    : Self-checking bench for hwpe_eai_slave_if against a queue model.
//  Revision : 1.0
// ============================================================================
module tb_hwpe_eai_slave_if;
    localparam int DEPTH  = 4;
    localparam int ITAG_W = 2;
    localparam int DATA_W = 32;

    typedef struct {
        logic [ITAG_W-1:0] itag;
        logic              xd;
        logic              ill;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hwpe_eai_slave_if_if #(.ITAG_W(ITAG_W), .DATA_W(DATA_W)) bus ();

    hwpe_eai_slave_if #(.DEPTH(DEPTH), .ITAG_W(ITAG_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t              exp_q [$];
    cmd_t              cmd_q [$];
    logic [DATA_W-1:0] comp_q [$];
    logic [ITAG_W-1:0] rsp_log [$];
    int                dec_pending = 0;
    int                accepts = 0;
    int                rsps = 0;
    int                errors = 0;
    int                checks = 0;
    logic [DATA_W-1:0] last_wdat;
    logic [ITAG_W-1:0] last_itag;
    logic              last_err;

    bit                dec_rand = 0;
    bit                rsp_rand = 0;
    bit                rsp_toggle = 0;
    bit                cmd_rand = 0;
    bit                force_en = 0;
    logic [DATA_W-1:0] force_wdat = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [DATA_W-1:0] instr);
        case (instr[6:0])
            7'h0B, 7'h2B, 7'h5B, 7'h7B: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] rand_instr();
        logic [6:0]        ops [4] = '{7'h0B, 7'h2B, 7'h5B, 7'h7B};
        logic [DATA_W-1:0] v;
        v = $urandom();
        if ($urandom_range(0, 3) != 0) v[6:0] = ops[$urandom_range(0, 3)];
        else                           v[6:0] = 7'h33;
        return v;
    endfunction

    // One clock: observe handshakes at negedge, update the model, advance to posedge+1
    task automatic step();
        exp_t e;
        logic [DATA_W-1:0] ew;
        @(negedge clk);
        if (rst) begin
            exp_q.delete(); cmd_q.delete(); comp_q.delete();
            dec_pending = 0;
        end else begin
            chk("cmd_valid", 32'(bus.cmd_valid), 32'(cmd_q.size() != 0));
            if (bus.cmd_valid && cmd_q.size() != 0) begin
                chk("cmd_instr", bus.cmd_instr, cmd_q[0].instr);
                chk("cmd_rs1", bus.cmd_rs1, cmd_q[0].rs1);
                chk("cmd_rs2", bus.cmd_rs2, cmd_q[0].rs2);
                if (bus.cmd_ready) begin
                    void'(cmd_q.pop_front());
                    dec_pending++;
                end
            end
            if (bus.done_valid && bus.done_ready) begin
                comp_q.push_back(bus.done_wdat);
                dec_pending--;
            end
            if (bus.eai_rsp_valid) begin
                chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    ew = '0;
                    if (!e.ill) begin
                        chk("rsp_has_completion", 32'(comp_q.size() != 0), 32'd1);
                        if (comp_q.size() != 0 && e.xd) ew = comp_q[0];
                    end
                    chk("rsp_itag", 32'(bus.eai_rsp_itag), 32'(e.itag));
                    chk("rsp_err", 32'(bus.eai_rsp_err), 32'(e.ill));
                    chk("rsp_wdat", bus.eai_rsp_wdat, ew);
                    if (bus.eai_rsp_ready) begin
                        void'(exp_q.pop_front());
                        if (!e.ill && comp_q.size() != 0) void'(comp_q.pop_front());
                        rsp_log.push_back(bus.eai_rsp_itag);
                        last_wdat = bus.eai_rsp_wdat;
                        last_itag = bus.eai_rsp_itag;
                        last_err  = bus.eai_rsp_err;
                        rsps++;
                    end
                end
            end
            if (bus.eai_req_valid && bus.eai_req_ready) begin
                e.itag = bus.eai_req_itag;
                e.xd   = bus.eai_req_instr[14];
                e.ill  = !is_legal(bus.eai_req_instr);
                exp_q.push_back(e);
                if (!e.ill) cmd_q.push_back('{bus.eai_req_instr, bus.eai_req_rs1, bus.eai_req_rs2});
                accepts++;
            end
            chk("outstanding_bound", 32'(exp_q.size() <= DEPTH + 1), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.done_valid = (dec_pending > 0) && (!dec_rand || $urandom_range(0, 3) != 0);
        bus.done_wdat  = force_en ? force_wdat : DATA_W'($urandom());
        if (rsp_toggle)    bus.eai_rsp_ready = ~bus.eai_rsp_ready;
        else if (rsp_rand) bus.eai_rsp_ready = 1'($urandom_range(0, 1));
        if (cmd_rand)      bus.cmd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_req(input logic [DATA_W-1:0] instr, input logic [ITAG_W-1:0] itag);
        int a0 = accepts;
        bus.eai_req_instr = instr;
        bus.eai_req_rs1   = $urandom();
        bus.eai_req_rs2   = $urandom();
        bus.eai_req_itag  = itag;
        bus.eai_req_valid = 1'b1;
        for (int i = 0; i < 100 && accepts == a0; i++) step();
        bus.eai_req_valid = 1'b0;
        chk("req_accept_timeout", 32'(accepts != a0), 32'd1);
    endtask

    task automatic wait_rsps(input int target);
        for (int i = 0; i < 200 && rsps < target; i++) step();
        chk("rsp_timeout", 32'(rsps >= target), 32'd1);
    endtask

    task automatic drain();
        bus.eai_req_valid = 1'b0;
        bus.cmd_ready     = 1'b1;
        bus.eai_rsp_ready = 1'b1;
        rsp_rand = 0; rsp_toggle = 0; cmd_rand = 0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int a0;
        int r0;
        bus.eai_req_valid = 1'b0;
        bus.eai_req_instr = '0;
        bus.eai_req_rs1   = '0;
        bus.eai_req_rs2   = '0;
        bus.eai_req_itag  = '0;
        bus.eai_rsp_ready = 1'b0;
        bus.cmd_ready     = 1'b0;
        bus.done_valid    = 1'b0;
        bus.done_wdat     = '0;

        // Reset state
        step(); step();
        chk("rst_rsp_valid", 32'(bus.eai_rsp_valid), 32'd0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.eai_req_ready), 32'd0);
        chk("rst_done_ready", 32'(bus.done_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(bus.eai_req_ready), 32'd1);
        chk("idle_done_ready", 32'(bus.done_ready), 32'd0);

        // Legal xd=1: writeback data passes through
        bus.cmd_ready = 1'b1; bus.eai_rsp_ready = 1'b1;
        force_en = 1; force_wdat = 32'h1234_5678;
        send_req(32'h0000_407B, 2'd1);
        wait_rsps(1);
        chk("t1_itag", 32'(last_itag), 32'd1);
        chk("t1_wdat", last_wdat, 32'h1234_5678);
        chk("t1_err", 32'(last_err), 32'd0);

        // Legal xd=0: writeback forced to zero
        force_wdat = 32'hFFFF_FFFF;
        send_req(32'h0000_007B, 2'd3);
        wait_rsps(2);
        chk("t2_wdat", last_wdat, 32'h0);
        chk("t2_err", 32'(last_err), 32'd0);
        force_en = 0;

        // Illegal: never reaches the decoder, answered two cycles after accept
        send_req(32'h0000_0033, 2'd2);
        chk("t3_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("t3_lat1_valid", 32'(bus.eai_rsp_valid), 32'd0);
        step();
        chk("t3_lat2_valid", 32'(bus.eai_rsp_valid), 32'd1);
        chk("t3_err", 32'(bus.eai_rsp_err), 32'd1);
        chk("t3_itag", 32'(bus.eai_rsp_itag), 32'd2);
        chk("t3_wdat", bus.eai_rsp_wdat, 32'h0);
        wait_rsps(3);

        // Decoder stalled: only one request fits behind the held command
        bus.cmd_ready = 1'b0;
        a0 = accepts;
        bus.eai_req_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            r0 = accepts;
            if (i == 0 || accepts != r0) begin
                bus.eai_req_instr = {17'($urandom()), 1'b1, 7'($urandom()), 7'h2B};
                bus.eai_req_itag  = ITAG_W'(i);
            end
            step();
        end
        bus.eai_req_valid = 1'b0;
        chk("t4_accepts", 32'(accepts - a0), 32'd1);
        chk("t4_cmd_held", 32'(bus.cmd_valid), 32'd1);
        drain();

        // Response stalled: FIFO plus response register bound the outstanding count
        bus.eai_rsp_ready = 1'b0;
        a0 = accepts;
        dec_rand = 1;
        for (int i = 0; i < 3 * DEPTH + 10; i++) begin
            bus.eai_req_valid = 1'b1;
            bus.eai_req_instr = rand_instr();
            bus.eai_req_itag  = ITAG_W'($urandom());
            step();
        end
        bus.eai_req_valid = 1'b0;
        chk("full_accepts", 32'(accepts - a0), 32'(DEPTH + 1));
        chk("full_req_ready", 32'(bus.eai_req_ready), 32'd0);
        drain();
        dec_rand = 0;

        // Ordering with toggling response ready, illegal in the middle
        r0 = rsps;
        rsp_toggle = 1;
        send_req(32'h0000_400B, 2'd0);
        send_req(32'h0000_402B, 2'd1);
        send_req(32'h0000_4033, 2'd2);
        send_req(32'h0000_005B, 2'd3);
        wait_rsps(r0 + 4);
        rsp_toggle = 0;
        for (int i = 0; i < 4; i++)
            chk("t5_order", 32'(rsp_log[r0 + i]), 32'(i));

        // Reset with three outstanding drops them all
        bus.eai_rsp_ready = 1'b0;
        bus.cmd_ready = 1'b1;
        send_req(32'h0000_400B, 2'd1);
        send_req(32'h0000_0033, 2'd2);
        send_req(32'h0000_407B, 2'd3);
        rst = 1'b1;
        step();
        chk("t6_rsp_valid", 32'(bus.eai_rsp_valid), 32'd0);
        chk("t6_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("t6_done_ready", 32'(bus.done_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("t6_post_rsp_valid", 32'(bus.eai_rsp_valid), 32'd0);
        chk("t6_post_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        bus.eai_rsp_ready = 1'b1;
        r0 = rsps;
        send_req(32'h0000_400B, 2'd0);
        wait_rsps(r0 + 1);
        chk("t6_new_itag", 32'(last_itag), 32'd0);
        chk("t6_new_err", 32'(last_err), 32'd0);

        // Randomized traffic
        dec_rand = 1; rsp_rand = 1; cmd_rand = 1;
        for (int i = 0; i < 400; i++) begin
            bus.eai_req_valid = 1'($urandom_range(0, 1));
            bus.eai_req_instr = rand_instr();
            bus.eai_req_rs1   = $urandom();
            bus.eai_req_rs2   = $urandom();
            bus.eai_req_itag  = ITAG_W'($urandom());
            step();
        end
        drain();
        dec_rand = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
